// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage.
// Owns the program counter, reads one instruction byte per cycle from a byte-wide memory with
// one-cycle read latency, assembles four bytes little-endian into a word, and offers it to the
// control unit over a valid/ready handshake. A branch redirect from downstream restarts fetch at
// the word-aligned target.
//
// Ports:
//   clk_i            clock, all state on rising edge
//   rst_ni           synchronous active-low reset
//   imem_addr_o      byte address to instruction memory (from registered state only)
//   imem_rdata_i     byte returned by memory one cycle after the address
//   instr_o          assembled instruction word
//   instr_pc_o       byte address of the first byte of instr_o
//   instr_valid_o    instr_o / instr_pc_o hold a complete instruction
//   instr_ready_i    control unit accepts instr_o this cycle
//   branch_valid_i   single-cycle redirect request
//   branch_target_i  redirect byte address (low bits forced to word alignment)
module instruction_fetch_unit #(
  parameter int unsigned WordSize           = 32,
  parameter int unsigned InstructDataLength = 8,
  parameter int unsigned InstructMemLength  = 64,
  localparam int unsigned PcW               = $clog2(InstructMemLength)
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  output logic [PcW-1:0]                imem_addr_o,
  input  logic [InstructDataLength-1:0] imem_rdata_i,
  output logic [WordSize-1:0]           instr_o,
  output logic [PcW-1:0]                instr_pc_o,
  output logic                          instr_valid_o,
  input  logic                          instr_ready_i,
  input  logic                          branch_valid_i,
  input  logic [PcW-1:0]                branch_target_i
);

  localparam int unsigned Lanes = WordSize / InstructDataLength;
  localparam int unsigned IdxW  = $clog2(Lanes);

  typedef enum logic [1:0] {StFetch, StLast, StValid} state_e;

  state_e                                     state_q, state_d;
  logic [PcW-1:0]                             pc_q, pc_d;
  logic [IdxW-1:0]                            idx_q, idx_d;
  // Only lanes 0..Lanes-2 are buffered; the final byte goes straight into instr_q.
  logic [Lanes-2:0][InstructDataLength-1:0]   lanes_q, lanes_d;
  logic [WordSize-1:0]                        instr_q, instr_d;
  logic [PcW-1:0]                             instr_pc_q, instr_pc_d;
  logic [IdxW-1:0]                            lane_idx;

  // Byte issued on the previous edge lands in the lane one below the current index.
  assign lane_idx = idx_q - IdxW'(1);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    idx_d      = idx_q;
    lanes_d    = lanes_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;

    unique case (state_q)
      StFetch: begin
        if (idx_q != '0) begin
          lanes_d[lane_idx] = imem_rdata_i;
        end
        if (idx_q == IdxW'(Lanes - 1)) begin
          idx_d   = '0;
          state_d = StLast;
        end else begin
          idx_d = idx_q + IdxW'(1);
        end
      end
      StLast: begin
        instr_d    = {imem_rdata_i, lanes_q};
        instr_pc_d = pc_q;
        state_d    = StValid;
      end
      StValid: begin
        if (instr_ready_i) begin
          pc_d    = pc_q + PcW'(Lanes);
          idx_d   = '0;
          state_d = StFetch;
        end
      end
      default: begin
        idx_d   = '0;
        state_d = StFetch;
      end
    endcase

    // Redirect wins over everything except reset; a coincident handshake still counts as taken.
    if (branch_valid_i) begin
      pc_d    = branch_target_i & ~PcW'(Lanes - 1);
      idx_d   = '0;
      state_d = StFetch;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= StFetch;
      pc_q       <= '0;
      idx_q      <= '0;
      lanes_q    <= '0;
      instr_q    <= '0;
      instr_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      idx_q      <= idx_d;
      lanes_q    <= lanes_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
    end
  end

  // Outside FETCH the address parks on the last byte of the current word.
  always_comb begin
    if (state_q == StFetch) begin
      imem_addr_o = pc_q + PcW'(idx_q);
    end else begin
      imem_addr_o = pc_q + PcW'(Lanes - 1);
    end
  end

  assign instr_o       = instr_q;
  assign instr_pc_o    = instr_pc_q;
  assign instr_valid_o = (state_q == StValid);

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Fetch stage that sits between the byte-wide instruction memory and the control unit. It owns the program counter, issues four sequential byte reads per instruction, and assembles them little-endian into one 32-bit instruction word. It hands the word to the control unit over a valid/ready handshake and accepts a branch redirect from downstream.

## Interface
- word_size, 32, instruction width delivered to the control unit
- instruct_data_length, 8, instruction memory data width (bytes per read)
- instruct_mem_length, 64, instruction memory depth in bytes; PC width = $clog2(instruct_mem_length)
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-low reset
- imem_addr  out  $clog2(instruct_mem_length)  byte address to instruction memory
- imem_rdata  in  instruct_data_length  byte returned by instruction memory, one cycle after address
- instr  out  word_size  assembled instruction
- instr_pc  out  $clog2(instruct_mem_length)  byte address of instr's first byte
- instr_valid  out  1  instr/instr_pc hold a complete instruction
- instr_ready  in  1  control unit accepts instr this cycle
- branch_valid  in  1  redirect request, single-cycle pulse
- branch_target  in  $clog2(instruct_mem_length)  redirect byte address

## Operation
- Instruction memory read latency is exactly 1 cycle: address registered at edge N, imem_rdata valid during cycle N+1.
- State machine: FETCH, LAST, VALID.
  - FETCH: byte_idx 0..3; imem_addr = (pc + byte_idx) mod instruct_mem_length (combinational from registers). At each edge with byte_idx>0, capture imem_rdata into byte lane byte_idx-1. After byte_idx 3 is issued -> LAST.
  - LAST: capture imem_rdata into lane 3, load instr with all four lanes, instr_pc <= pc, -> VALID. imem_addr holds pc+3.
  - VALID: instr_valid=1. On instr_valid && instr_ready: pc <= (pc+4) mod depth, byte_idx <= 0, -> FETCH. Otherwise hold.
- Byte order: byte at pc -> instr[7:0], pc+1 -> [15:8], pc+2 -> [23:16], pc+3 -> [31:24].
- PC arithmetic modulo instruct_mem_length; pc+4 from 60 wraps to 0; byte addresses pc+i wrap likewise.
- Branch: branch_valid in any state has priority. pc <= {branch_target[msb:2], 2'b00} (low two bits forced to zero), byte_idx <= 0, partial lanes discarded, -> FETCH; instr_valid low next cycle.
- Branch coincident with handshake in VALID: current instr counts as accepted; next pc is the aligned branch target, not pc+4.
- Reset (rst=0 at an edge, any state, including mid-fetch): pc=0, byte_idx=0, lanes=0, instr=0, instr_pc=0, instr_valid=0, state=FETCH, imem_addr=0. Reset overrides branch.

## Timing
- Cycle 0 = first edge with rst=1. Edges 0..3 issue addresses pc..pc+3 (FETCH); edge 4 is LAST; instr_valid high from the cycle after edge 4 through edge 5 onward.
- Fetch latency: 5 cycles from FETCH entry to instr_valid. Throughput with instr_ready tied high: one instruction per 6 cycles.
- instr, instr_pc stable while instr_valid && !instr_ready; instr_valid never drops without a handshake, branch or reset.
- instr_valid is registered; no combinational path from instr_ready or branch_valid to any output except imem_addr (via the registered pc).

## Test plan
- Memory bytes 0..3 = 78,56,34,12, instr_ready=1 after reset -> instr_valid first high after edge 4, instr=0x12345678, instr_pc=0; next instr_pc=4 six cycles later.
- instr_ready=0 for 10 cycles while valid -> instr/instr_pc frozen, imem_addr stays 3; raise ready -> one handshake, pc=4, FETCH resumes.
- Branch to 60, bytes 60..63 = EF,BE,AD,DE -> instr=0xDEADBEEF, instr_pc=60; following instruction has instr_pc=0 (wrap).
- branch_valid with target 0x0D during byte_idx 2 of fetch at pc 8 -> partial bytes discarded, next delivered instr_pc=12 with bytes 12..15.
- Branch to 32 in same cycle as handshake at pc 4 -> pc 4 instruction accepted once; next instr_pc=32, not 8.
- rst=0 for one edge during byte_idx 2 -> instr_valid=0, instr=0, imem_addr=0; after release fetch restarts at pc 0 with 5-cycle latency.
